// File: rtl/knight_anim_sequencer.sv
// Knight sprite sequencer: per-pixel ROM address generation (with optional
// horizontal mirror and screen-edge clipping) plus the idle/walk/attack
// animation state machine, whose frame changes land only on vsync rising edges.
module knight_anim_sequencer #(
  parameter int SPRITE_W    = 50,
  parameter int SPRITE_H    = 64,
  parameter int FRAME_TICKS = 6
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        facing_left,
  input  logic        walk,
  input  logic        attack_req,
  output logic [11:0] rom_address,
  output logic        sprite_on,
  output logic [2:0]  frame_sel,
  output logic        attack_busy,
  output logic        attack_done
);

  localparam int CNT_W = $clog2(FRAME_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WALK_A = 3'd1,
    WALK_B = 3'd2,
    ATK1   = 3'd3,
    ATK2   = 3'd4
  } state_t;

  // Row-major ROM index; the product never exceeds 12 bits inside the box.
  function automatic logic [11:0] row_major(input logic [10:0] row,
                                            input logic [10:0] col);
    return 12'(22'(row) * 22'(SPRITE_W) + 22'(col));
  endfunction

  // Address path inputs widened to 11 bits so pos+size never wraps at the edge.
  logic [10:0] x_p0, y_p0, px_p0, py_p0;
  logic [10:0] dx_p0, dy_p0, col_p0;
  logic        inside_p0;
  logic [11:0] addr_p0;

  assign x_p0      = {1'b0, DrawX};
  assign y_p0      = {1'b0, DrawY};
  assign px_p0     = {1'b0, pos_x};
  assign py_p0     = {1'b0, pos_y};
  assign dx_p0     = x_p0 - px_p0;
  assign dy_p0     = y_p0 - py_p0;
  assign inside_p0 = (x_p0 >= px_p0) && (x_p0 < px_p0 + 11'(SPRITE_W)) &&
                     (y_p0 >= py_p0) && (y_p0 < py_p0 + 11'(SPRITE_H));
  assign col_p0    = facing_left ? (11'(SPRITE_W - 1) - dx_p0) : dx_p0;
  assign addr_p0   = row_major(dy_p0, col_p0);

  // ---- stage p0 -> registered outputs ----
  // Register the address and in-box flag (one cycle of latency).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      sprite_on   <= 1'b0;
    end else begin
      rom_address <= inside_p0 ? addr_p0 : 12'd0;
      sprite_on   <= inside_p0;
    end
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             done_nx;
  logic             take_attack;
  logic             vsync_prev;
  logic             pending;
  logic             tick;

  assign tick      = vsync & ~vsync_prev;
  assign frame_sel = state;

  // Edge detector history, attack-request latch and busy flag.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vsync_prev  <= 1'b0;
      pending     <= 1'b0;
      attack_busy <= 1'b0;
    end else begin
      vsync_prev <= vsync;
      if (take_attack)
        pending <= 1'b0;
      else if (attack_req && !attack_busy)
        pending <= 1'b1;
      if (attack_done)
        attack_busy <= 1'b0;
      else if (attack_req && !attack_busy)
        attack_busy <= 1'b1;
    end
  end

  // Animation state, hold counter and completion pulse registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      attack_done <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      attack_done <= done_nx;
    end
  end

  // Next-state logic; everything advances only on a vsync tick.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    done_nx     = 1'b0;
    take_attack = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (pending) begin
            state_nx    = ATK1;
            cnt_nx      = '0;
            take_attack = 1'b1;
          end else if (walk) begin
            state_nx = WALK_A;
            cnt_nx   = '0;
          end
        end
        WALK_A, WALK_B: begin
          if (pending) begin
            state_nx    = ATK1;
            cnt_nx      = '0;
            take_attack = 1'b1;
          end else if (!walk) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = (state == WALK_A) ? WALK_B : WALK_A;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ATK1: begin
          if (cnt == CNT_LAST) begin
            state_nx = ATK2;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ATK2: begin
          if (cnt == CNT_LAST) begin
            state_nx = walk ? WALK_A : IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knight_anim_sequencer.sv
// Scoreboard bench for knight_anim_sequencer: a stimulus process drives
// directed and random traffic and pushes the reference model's expected
// outputs; a monitor pops and compares them on every falling edge.
module tb_knight_anim_sequencer;

  localparam int SW = 50;
  localparam int SH = 64;
  localparam int FT = 6;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic        facing_left = 1'b0, walk = 1'b0, attack_req = 1'b0;
  logic [11:0] rom_address;
  logic        sprite_on;
  logic [2:0]  frame_sel;
  logic        attack_busy, attack_done;

  knight_anim_sequencer #(.SPRITE_W(SW), .SPRITE_H(SH), .FRAME_TICKS(FT)) dut (
    .vga_clk(vga_clk), .reset(reset), .vsync(vsync),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
    .facing_left(facing_left), .walk(walk), .attack_req(attack_req),
    .rom_address(rom_address), .sprite_on(sprite_on), .frame_sel(frame_sel),
    .attack_busy(attack_busy), .attack_done(attack_done)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int addr;
    int on;
    int fs;
    int busy;
    int done;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit stim_done = 0;

  // Reference model: mode 0=idle, 1=walk, 2=attack; n counts ticks spent in the mode.
  int m_mode = 0, m_n = 0, m_pend = 0, m_busy = 0, m_done = 0, m_vprev = 0;

  function automatic void chk(string nm, int act, int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endfunction

  function automatic int model_frame();
    if (m_mode == 1) return 1 + ((m_n / FT) % 2);
    if (m_mode == 2) return (m_n < FT) ? 3 : 4;
    return 0;
  endfunction

  // Advance one clock: evaluate the model on the inputs seen at this edge.
  task automatic step();
    exp_t e;
    int x, y, px, py, col, tick, p_old, b_old, d_old;
    @(posedge vga_clk);
    if (reset) begin
      m_mode = 0; m_n = 0; m_pend = 0; m_busy = 0; m_done = 0; m_vprev = 0;
      e.addr = 0; e.on = 0;
    end else begin
      x = DrawX; y = DrawY; px = pos_x; py = pos_y;
      if (x >= px && x < px + SW && y >= py && y < py + SH) begin
        col = facing_left ? (SW - 1 - (x - px)) : (x - px);
        e.addr = (y - py) * SW + col;
        e.on = 1;
      end else begin
        e.addr = 0;
        e.on = 0;
      end
      tick = (vsync && !m_vprev) ? 1 : 0;
      m_vprev = vsync;
      p_old = m_pend; b_old = m_busy; d_old = m_done;
      m_done = 0;
      if (d_old) m_busy = 0;
      else if (attack_req && !b_old) begin m_busy = 1; m_pend = 1; end
      if (tick) begin
        if (m_mode != 2 && p_old) begin
          m_mode = 2; m_n = 0; m_pend = 0;
        end else if (m_mode == 0) begin
          if (walk) begin m_mode = 1; m_n = 0; end
        end else if (m_mode == 1) begin
          if (!walk) begin m_mode = 0; m_n = 0; end
          else m_n = (m_n + 1) % (2 * FT);
        end else begin
          m_n++;
          if (m_n == 2 * FT) begin
            m_done = 1;
            m_mode = walk ? 1 : 0;
            m_n = 0;
          end
        end
      end
    end
    e.fs = model_frame();
    e.busy = m_busy;
    e.done = m_done;
    q.push_back(e);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1; step(); step();
      vsync = 1'b0; step(); step();
    end
  endtask

  // Monitor: compare every registered output against the popped expectation.
  always @(negedge vga_clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rom_address", int'(rom_address), e.addr);
      chk("sprite_on", int'(sprite_on), e.on);
      chk("frame_sel", int'(frame_sel), e.fs);
      chk("attack_busy", int'(attack_busy), e.busy);
      chk("attack_done", int'(attack_done), e.done);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    int vper;
    reset = 1'b1; step(); step();
    reset = 1'b0;

    // Address path directed cases.
    pos_x = 10'd100; pos_y = 10'd50; facing_left = 1'b0;
    DrawX = 10'd100; DrawY = 10'd50; step();
    @(negedge vga_clk); chk("dir_origin_on", int'(sprite_on), 1);
    DrawX = 10'd149; DrawY = 10'd113; step();
    @(negedge vga_clk); chk("dir_corner_addr", int'(rom_address), 3199);
    DrawX = 10'd150; step();
    @(negedge vga_clk); chk("dir_right_off", int'(sprite_on), 0);
    facing_left = 1'b1; DrawX = 10'd100; DrawY = 10'd51; step();
    @(negedge vga_clk); chk("dir_mirror_left", int'(rom_address), 99);
    DrawX = 10'd149; step();
    @(negedge vga_clk); chk("dir_mirror_right", int'(rom_address), 50);
    facing_left = 1'b0; pos_x = 10'd620; DrawX = 10'd639; DrawY = 10'd60; step();
    @(negedge vga_clk); chk("dir_clip_addr", int'(rom_address), 10 * 50 + 19);
    DrawX = 10'd5; step();
    @(negedge vga_clk); chk("dir_clip_nowrap", int'(sprite_on), 0);

    // Attack while idle, with an ignored second request at tick 3.
    walk = 1'b0;
    attack_req = 1'b1; step(); attack_req = 1'b0; step();
    ticks(2);
    attack_req = 1'b1; vsync = 1'b1; step(); attack_req = 1'b0; step();
    vsync = 1'b0; step(); step();
    ticks(12);

    // Walk loop, attack during walk, return to walk, then stop.
    walk = 1'b1; ticks(14);
    attack_req = 1'b1; step(); attack_req = 1'b0;
    ticks(14);
    walk = 1'b0; ticks(2);

    // Request coinciding with a tick is deferred to the following tick.
    attack_req = 1'b1; vsync = 1'b1; step(); attack_req = 1'b0; step();
    vsync = 1'b0; step(); step();
    ticks(8);
    // Reset while in ATK2.
    reset = 1'b1; step(); reset = 1'b0;
    @(negedge vga_clk); chk("dir_reset_done", int'(attack_done), 0);
    chk("dir_reset_frame", int'(frame_sel), 0);
    step(); step();

    // Randomized traffic.
    vcnt = 0; vper = 4;
    for (int c = 0; c < 6000; c++) begin
      if (c % 400 == 0) begin
        pos_x = 10'($urandom_range(0, 639));
        pos_y = 10'($urandom_range(0, 479));
        facing_left = 1'($urandom_range(0, 1));
      end
      DrawX = 10'(int'(pos_x) + $urandom_range(0, 70) - 10);
      DrawY = 10'(int'(pos_y) + $urandom_range(0, 80) - 8);
      if ($urandom_range(0, 9) == 0) facing_left = ~facing_left;
      vcnt++;
      if (vcnt >= vper) begin
        vsync = ~vsync; vcnt = 0; vper = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 199) == 0) walk = ~walk;
      attack_req = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 1999) == 0);
      step();
    end
    reset = 1'b0; attack_req = 1'b0;
    step(); step();
    @(negedge vga_clk);
    @(negedge vga_clk);
    stim_done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/knight_anim_sequencer.md
Name: knight_anim_sequencer

Overview:
- Per-pixel ROM address generator and animation state machine for the 50x64 knight sprite set.
- Places the sprite at (pos_x, pos_y), with optional horizontal mirror.
- Drives rom_address, sprite_on and frame_sel to the frame ROM/palette mux.
- Frame changes take effect only at vsync rising edges, so no tearing mid-frame.

Parameters:
- SPRITE_W, 50, sprite width in pixels.
- SPRITE_H, 64, sprite height in pixels.
- FRAME_TICKS, 6, vsync periods each animation frame is held (>=1).

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- vsync  in  1  VGA vsync level; rising edge = frame tick.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- pos_x  in  10  sprite top-left column.
- pos_y  in  10  sprite top-left row.
- facing_left  in  1  1 = mirror horizontally.
- walk  in  1  level; 1 = walk loop when not attacking.
- attack_req  in  1  single-cycle request pulse.
- rom_address  out  12  registered ROM address, row-major.
- sprite_on  out  1  registered; current pixel is inside the sprite box.
- frame_sel  out  3  0=IDLE, 1=WALK_A, 2=WALK_B, 3=ATK1, 4=ATK2.
- attack_busy  out  1  attack accepted and not yet finished.
- attack_done  out  1  one-cycle pulse at attack completion.

Behaviour:
- Reset (synchronous, active-high): applies on the next posedge.
  - rom_address=0, sprite_on=0, frame_sel=0, attack_busy=0, attack_done=0.
  - State=IDLE, tick counter=0, pending=0, vsync_prev=0.
- Tick detection: tick = vsync & ~vsync_prev, with vsync_prev registered every cycle.
- Address path, 1-cycle latency: outputs at cycle n+1 reflect inputs at cycle n.
  - dx = DrawX - pos_x, dy = DrawY - pos_y, both 11-bit unsigned.
  - inside = DrawX>=pos_x && DrawX<pos_x+SPRITE_W && DrawY>=pos_y && DrawY<pos_y+SPRITE_H.
  - All compare sums use 11 bits, so pos_x=620 clips at the screen edge without wrap.
  - col = facing_left ? SPRITE_W-1-dx : dx.
  - rom_address = dy*SPRITE_W + col when inside, else 0.
  - sprite_on = inside.
- Attack request handling:
  - attack_req while attack_busy=0: sets pending, and attack_busy=1 next cycle.
  - attack_req while attack_busy=1: ignored, not queued.
- FSM: states IDLE, WALK_A, WALK_B, ATK1, ATK2; evaluated only on tick cycles; frame_sel = state encoding.
  - IDLE/WALK_x with pending on tick: go to ATK1, clear pending, counter=0. Attack has priority over walk.
  - IDLE, tick, walk=1: go to WALK_A, counter=0.
  - WALK_A/WALK_B, tick, walk=0: go to IDLE, counter=0.
  - WALK_A, tick, walk=1: counter++; at FRAME_TICKS-1 go to WALK_B, counter=0. WALK_B mirrors this back to WALK_A (loops).
  - ATK1, tick: counter++; at FRAME_TICKS-1 go to ATK2, counter=0.
  - ATK2, tick: counter++; at FRAME_TICKS-1, go to WALK_A if walk else IDLE, counter=0.
    - Same cycle: attack_done=1 for exactly one cycle, attack_busy=0 the next cycle.
  - ATK1/ATK2 ignore walk.
- Simultaneous events:
  - attack_req on the same cycle as a tick: not used by that tick; the attack starts at the following tick.
  - attack_req on the same cycle as attack_done: ignored, because busy is still 1.
- Counter width: $clog2(FRAME_TICKS+1); never exceeds FRAME_TICKS-1.
- Reset mid-attack: immediately returns to IDLE. No attack_done pulse; pending cleared.

Test Plan:
- Reset, then DrawX=100, DrawY=50, pos=(100,50), facing_left=0 -> one cycle later sprite_on=1, rom_address=0. DrawX=149, DrawY=113 -> rom_address=3199. DrawX=150 -> sprite_on=0, rom_address=0.
- Mirror: facing_left=1, pos=(100,50), DrawX=100, DrawY=51 -> rom_address=99. DrawX=149 -> rom_address=50.
- Clip: pos_x=620, DrawX=639 -> sprite_on=1, rom_address=dy*50+19. DrawX=5 -> sprite_on=0 (no wrap).
- Attack, FRAME_TICKS=6, walk=0: pulse attack_req -> attack_busy=1 next cycle.
  - frame_sel=3 after tick 1, =4 after tick 7.
  - At tick 13: frame_sel=0 and attack_done high for exactly 1 cycle; attack_busy=0 next cycle.
  - Second attack_req at tick 3 produces no effect.
- Walk: walk=1 -> frame_sel 1 after tick 1, 2 after tick 7, 1 after tick 13. walk=0 -> frame_sel 0 at next tick.
  - attack_req during walk -> frame_sel=3 at the next tick; after ATK2 returns to 1 while walk=1.
- Reset asserted while frame_sel=4 -> next cycle frame_sel=0, attack_busy=0, attack_done stays 0.
